mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-ported synchronous memory between the core's instruction-fetch port and its data load/store port. It sits between the processor core and the unified memory. It grants one requester at a time, drives the memory command, waits the memory's fixed read latency, and returns data with a one-cycle acknowledge. It also produces a stall for the core while any request is outstanding.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported synchronous memory between the instruction-fetch
// port and the data load/store port. One transaction at a time runs through
// IDLE -> ISSUE -> (WAIT) -> ACK; the owner's ack is a one-cycle pulse.
// MEM_LAT is the memory read latency (legal 1..7).
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to replace the fixed
// data-over-fetch priority by round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iIReq,
    input  logic [31:0] iIAddr,
    output logic        oIAck,
    output logic [31:0] oIData,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWData,
    output logic        oDAck,
    output logic [31:0] oDRData,
    output logic [31:0] oMemAddr,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData,
    output logic        oStall
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

    // Counter reload: WAIT lasts MEM_LAT cycles, ending when the count is 0.
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

    state_t      state_reg;
    logic        owner_data_reg;   // 1: data port owns the current transaction
    logic        write_reg;        // current transaction is a store
    logic [2:0]  wait_cnt_reg;
    logic        i_ack_reg;
    logic        d_ack_reg;
    logic [31:0] i_data_reg;
    logic [31:0] d_data_reg;
    logic [31:0] mem_addr_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [31:0] mem_wdata_reg;

    logic        grant_data;       // winner when arbitrating in IDLE

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1: fetch wins the next tie (data was granted most recently).
    logic        prefer_fetch_reg;

    // Round-robin choice: only a tie consults the pointer.
    always_comb begin
        grant_data = iDReq;
        if (iDReq && iIReq) begin
            grant_data = ~prefer_fetch_reg;
        end
    end

    // Pointer follows every grant so the other port wins the next tie.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prefer_fetch_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && (iIReq || iDReq)) begin
            prefer_fetch_reg <= grant_data;
        end
    end
`else
    // Fixed priority: the data access belongs to the older instruction.
    always_comb begin
        grant_data = iDReq;
    end
`endif

    // Transaction sequencer: arbitration, memory command, latency wait, ack.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_reg      <= ST_IDLE;
            owner_data_reg <= 1'b0;
            write_reg      <= 1'b0;
            wait_cnt_reg   <= 3'd0;
            i_ack_reg      <= 1'b0;
            d_ack_reg      <= 1'b0;
            i_data_reg     <= 32'd0;
            d_data_reg     <= 32'd0;
            mem_addr_reg   <= 32'd0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_wdata_reg  <= 32'd0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (iIReq || iDReq) begin
                        owner_data_reg <= grant_data;
                        if (grant_data) begin
                            mem_addr_reg  <= iDAddr;
                            mem_wdata_reg <= iDWData;
                            mem_read_reg  <= ~iDWe;
                            mem_write_reg <= iDWe;
                            write_reg     <= iDWe;
                        end else begin
                            // Fetch port is read-only.
                            mem_addr_reg  <= iIAddr;
                            mem_read_reg  <= 1'b1;
                            write_reg     <= 1'b0;
                        end
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (write_reg) begin
                        d_ack_reg <= 1'b1;
                        state_reg <= ST_ACK;
                    end else begin
                        wait_cnt_reg <= WAIT_LOAD;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 3'd0) begin
                        if (owner_data_reg) begin
                            d_data_reg <= iMemRData;
                            d_ack_reg  <= 1'b1;
                        end else begin
                            i_data_reg <= iMemRData;
                            i_ack_reg  <= 1'b1;
                        end
                        state_reg <= ST_ACK;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                ST_ACK: begin
                    // No arbitration here: the acked port's req is still high.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign oIAck     = i_ack_reg;
    assign oIData    = i_data_reg;
    assign oDAck     = d_ack_reg;
    assign oDRData   = d_data_reg;
    assign oMemAddr  = mem_addr_reg;
    assign oMemRead  = mem_read_reg;
    assign oMemWrite = mem_write_reg;
    assign oMemWData = mem_wdata_reg;
    assign oStall    = (iIReq & ~i_ack_reg) | (iDReq & ~d_ack_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each with a small memory model returning a known word
// exactly MEM_LAT cycles after a read strobe and garbage otherwise.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst1_n, rst3_n;
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;

    logic        iack1, dack1, rd1, wr1, stall1;
    logic [31:0] idata1, drdata1, maddr1, mwdata1, rdata1;
    logic        iack3, dack3, rd3, wr3, stall3;
    logic [31:0] idata3, drdata3, maddr3, mwdata3, rdata3;

    int n_errors = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
        .iClk(clk), .iRst_n(rst1_n),
        .iIReq(ireq), .iIAddr(iaddr), .oIAck(iack1), .oIData(idata1),
        .iDReq(dreq), .iDWe(dwe), .iDAddr(daddr), .iDWData(dwdata),
        .oDAck(dack1), .oDRData(drdata1),
        .oMemAddr(maddr1), .oMemRead(rd1), .oMemWrite(wr1), .oMemWData(mwdata1),
        .iMemRData(rdata1), .oStall(stall1)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
        .iClk(clk), .iRst_n(rst3_n),
        .iIReq(ireq), .iIAddr(iaddr), .oIAck(iack3), .oIData(idata3),
        .iDReq(dreq), .iDWe(dwe), .iDAddr(daddr), .iDWData(dwdata),
        .oDAck(dack3), .oDRData(drdata3),
        .oMemAddr(maddr3), .oMemRead(rd3), .oMemWrite(wr3), .oMemWData(mwdata3),
        .iMemRData(rdata3), .oStall(stall3)
    );

    // Memory contents: two fixed words, everything else derived from address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0040_0000: return 32'h8C08_0004;
            32'h1001_0004: return 32'h1234_5678;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Memory models: read strobe and address delayed by the read latency.
    logic        rv1;
    logic [31:0] ra1;
    logic [2:0]  rv3;
    logic [31:0] ra3 [3];
    always @(posedge clk) begin
        rv1    <= rd1;
        ra1    <= maddr1;
        rv3    <= {rv3[1:0], rd3};
        ra3[0] <= maddr3;
        ra3[1] <= ra3[0];
        ra3[2] <= ra3[1];
    end
    assign rdata1 = rv1 ? mem_word(ra1) : 32'hBAD0_BAD0;
    assign rdata3 = rv3[2] ? mem_word(ra3[2]) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  n_acks;
    bit  got_d [4];
    bit  exp_d [4];

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0;
        ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dwdata = 32'd0;
        rv3 = 3'd0; rv1 = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_iack", iack1, 0);
        check("rst_idata", idata1, 0);
        check("rst_dack", dack1, 0);
        check("rst_drdata", drdata1, 0);
        check("rst_maddr", maddr1, 0);
        check("rst_mread", rd1, 0);
        check("rst_mwrite", wr1, 0);
        check("rst_mwdata", mwdata1, 0);
        check("rst_stall", stall1, 0);
        rst1_n = 1'b1;
        step();

        // Fetch, MEM_LAT=1
        $display("txn: fetch 00400000 lat1");
        step();
        ireq = 1'b1; iaddr = 32'h0040_0000;
        #1;
        check("f_c0_stall", stall1, 1);
        step();
        check("f_c1_read", rd1, 1);
        check("f_c1_addr", maddr1, 32'h0040_0000);
        check("f_c1_stall", stall1, 1);
        step();
        check("f_c2_read", rd1, 0);
        check("f_c2_iack", iack1, 0);
        check("f_c2_stall", stall1, 1);
        step();
        check("f_c3_iack", iack1, 1);
        check("f_c3_idata", idata1, 32'h8C08_0004);
        check("f_c3_stall", stall1, 0);
        ireq = 1'b0;
        step();
        check("f_c4_iack", iack1, 0);
        check("f_c4_idata_hold", idata1, 32'h8C08_0004);

        // Store
        $display("txn: store 10010000 <= deadbeef");
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h1001_0000; dwdata = 32'hDEAD_BEEF;
        step();
        check("s_c1_write", wr1, 1);
        check("s_c1_read", rd1, 0);
        check("s_c1_addr", maddr1, 32'h1001_0000);
        check("s_c1_wdata", mwdata1, 32'hDEAD_BEEF);
        step();
        check("s_c2_dack", dack1, 1);
        check("s_c2_write", wr1, 0);
        check("s_c2_read", rd1, 0);
        check("s_c2_drdata", drdata1, 0);
        dreq = 1'b0; dwe = 1'b0;
        step();
        check("s_c3_dack", dack1, 0);
        check("s_c3_read", rd1, 0);

        // Reset pulse to restore the data-first pointer, then simultaneous requests
        rst1_n = 1'b0;
        step();
        check("rst2_drdata", drdata1, 0);
        rst1_n = 1'b1;
        step();
        $display("txn: fetch 00400004 + load 10010008 together");
        ireq = 1'b1; iaddr = 32'h0040_0004;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h1001_0008;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            check($sformatf("sim_c%0d_dack", cyc), dack1, 32'(cyc == 3));
            check($sformatf("sim_c%0d_iack", cyc), iack1, 32'(cyc == 7));
            check($sformatf("sim_c%0d_read", cyc), rd1, 32'(cyc == 1 || cyc == 5));
            if (cyc == 1) check("sim_c1_addr", maddr1, 32'h1001_0008);
            if (cyc == 5) check("sim_c5_addr", maddr1, 32'h0040_0004);
            if (cyc == 3) begin
                check("sim_c3_drdata", drdata1, 32'h1001_0008 ^ 32'h5A5A_5A5A);
                dreq = 1'b0;
            end
            if (cyc == 7) begin
                check("sim_c7_idata", idata1, 32'h0040_0004 ^ 32'h5A5A_5A5A);
                ireq = 1'b0;
            end
        end

        // Both ports requesting continuously: grant order over 4 transactions
        $display("txn: continuous contention, 4 grants");
        ireq = 1'b1; iaddr = 32'h0040_0008;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h1001_000C;
        n_acks = 0;
        for (int cyc = 0; cyc < 60 && n_acks < 4; cyc++) begin
            step();
            if (iack1 || dack1) begin
                got_d[n_acks] = dack1;
                n_acks++;
            end
        end
        ireq = 1'b0; dreq = 1'b0;
        check("cont_acks", n_acks, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d[k] = (k % 2 == 0);
`else
            exp_d[k] = 1'b1;
`endif
            check($sformatf("cont_grant%0d", k), 32'(got_d[k]), 32'(exp_d[k]));
        end
        repeat (4) step();

        // MEM_LAT=3 instance
        rst1_n = 1'b0;
        rst3_n = 1'b1;
        step();
        $display("txn: load 10010004 lat3");
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h1001_0004;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            check($sformatf("l3_c%0d_dack", cyc), dack3, 32'(cyc == 5));
            check($sformatf("l3_c%0d_drdata", cyc), drdata3,
                  (cyc >= 5) ? 32'h1234_5678 : 32'd0);
            if (cyc == 5) dreq = 1'b0;
        end

        // Reset in cycle 2 of a MEM_LAT=3 fetch
        $display("txn: fetch 00400000 lat3 with reset in cycle 2");
        ireq = 1'b1; iaddr = 32'h0040_0000;
        step();
        check("ra_c1_read", rd3, 1);
        check("ra_c1_addr", maddr3, 32'h0040_0000);
        step();
        rst3_n = 1'b0;
        #1;
        check("ra_rst_addr", maddr3, 0);
        check("ra_rst_read", rd3, 0);
        check("ra_rst_write", wr3, 0);
        check("ra_rst_iack", iack3, 0);
        check("ra_rst_dack", dack3, 0);
        check("ra_rst_drdata", drdata3, 0);
        check("ra_rst_wdata", mwdata3, 0);
        step();
        check("ra_c3_iack", iack3, 0);
        step();
        check("ra_c4_iack", iack3, 0);
        step();
        rst3_n = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            step();
            check($sformatf("rr_r%0d_iack", r), iack3, 32'(r == 5));
            if (r == 1) check("rr_r1_read", rd3, 1);
            if (r == 5) begin
                check("rr_r5_idata", idata3, 32'h8C08_0004);
                ireq = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
